// File: rtl/mult_div_unit.sv
// Sequential radix-2 multiply/divide engine owning the HI/LO registers.
// Fixed 33-cycle latency: one launch edge, 32 RUN iterations, one FIX edge.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic        sa, sb;
  logic [31:0] a_raw;
  logic [31:0] opnd;
  logic [63:0] acc;

  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] add_sum, sub_diff;
  logic [63:0] acc_next;
  logic [63:0] mult_res;
  logic [31:0] q_fix, r_fix;
  logic        neg_q, neg_r;

  always_comb begin
    a_neg = ~op[0] & a[31];
    b_neg = ~op[0] & b[31];
    abs_a = a_neg ? -a : a;
    abs_b = b_neg ? -b : b;

    // Multiply shifts {P, multiplier} right; divide shifts {rem, quot} left.
    add_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
    sub_diff = acc[63:31] - {1'b0, opnd};
    acc_next = acc;
    if (!op_r[1]) begin
      acc_next = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};
    end else begin
      acc_next = sub_diff[32] ? {acc[62:0], 1'b0}
                              : {sub_diff[31:0], acc[30:0], 1'b1};
    end

    neg_q    = ~op_r[0] & (sa ^ sb);
    neg_r    = ~op_r[0] & sa;
    mult_res = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[31:0]  : acc[31:0];
    r_fix    = neg_r ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            sa    <= a_neg;
            sb    <= b_neg;
            a_raw <= a;
            opnd  <= op[1] ? abs_b : abs_a;
            acc   <= {32'd0, (op[1] ? abs_a : abs_b)};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (!op_r[1]) begin
            hi <= mult_res[63:32];
            lo <= mult_res[31:0];
          end else if (opnd == 32'd0) begin
            hi       <= a_raw;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi       <= r_fix;
            lo       <= q_fix;
            div_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with per-cycle compare,
// plus directed vectors with hand-computed results.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference result computed with plain wide arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y, output bit dz);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, p;
    dz = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    p  = '0;
    case (o)
      2'd0: p = sx * sy;
      2'd1: p = ux * uy;
      default: begin
        if (y == 32'd0) begin
          dz = 1'b1;
          p  = {x, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {ux[31:0] % uy[31:0], ux[31:0] / uy[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Cycle model: a countdown of remaining edges replaces any notion of states.
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo;
  int          m_left;
  logic [63:0] m_res;
  bit          m_isdiv, m_resdz;

  always @(posedge clk) begin
    bit dzt;
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy  <= 1'b1;
          m_left  <= 32;
          m_res   <= ref_result(op, a, b, dzt);
          m_resdz <= dzt;
          m_isdiv <= op[1];
        end else begin
          if (hi_we) m_hi <= wdata;
          if (lo_we) m_lo <= wdata;
        end
      end else if (m_left == 0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
        if (m_isdiv) m_dz <= m_resdz;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
      chk("cyc_div_zero", {31'd0, div_zero}, {31'd0, m_dz});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // Called at a negedge; start is sampled at the following posedge (E0).
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      fails++;
      tests++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int n;
    launch(o, x, y);
    wait_done(n);
    chk({name, "_latency"}, n, 33);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  initial begin
    int n;
    int seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);

    // Reset during RUN aborts without a result.
    launch(2'd0, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    run_op("mult_neg", 2'd0, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg", 2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_zero", 2'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
    chk("dz_set", {31'd0, div_zero}, 32'd1);
    run_op("mult_keep_dz", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6);
    chk("dz_kept", {31'd0, div_zero}, 32'd1);
    run_op("divu_clr", 2'd3, 32'd10, 32'd3, 32'd1, 32'd3);
    chk("dz_clr", {31'd0, div_zero}, 32'd0);

    // Start while busy is dropped.
    launch(2'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ign_latency", n, 28);
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);
    // Start on the done cycle is accepted.
    run_op("b2b", 2'd3, 32'd10, 32'd3, 32'd1, 32'd3);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'hA5A5_A5A5);

    launch(2'd1, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_busy", lo, 32'd3);
    wait_done(n);
    chk("mtlo_busy_lo", lo, 32'd6);

    lo_we = 1'b1; wdata = 32'h55;
    launch(2'd3, 32'd9, 32'd2);
    lo_we = 1'b0;
    chk("mtlo_start_lo", lo, 32'd6);
    chk("mtlo_start_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("mtlo_start_res", lo, 32'd4);

    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", hi, 32'h1357_9BDF);
    chk("mt_both_lo", lo, 32'h1357_9BDF);

    for (int i = 0; i < 8; i++) begin
      launch(2'(i), $urandom, (i == 6) ? 32'd0 : $urandom);
      wait_done(n);
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle integer multiply/divide unit that owns the HI/LO registers. Its `hi` and `lo` outputs feed data inputs of the 32-bit 4:1 result-select mux in the execute/write-back path, alongside the ALU result. It is a sequential radix-2 engine: one operation in flight, fixed latency, and a `busy`/`done` handshake to the control unit.

## Interface
- No parameters; the data width is fixed at 32.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: launch operation; sampled only when `busy`=0.
- `op` input 2: operation select.
  - 00 = MULT (signed).
  - 01 = MULTU.
  - 10 = DIV (signed).
  - 11 = DIVU.
- `a` input 32: multiplicand / dividend; sampled with `start`.
- `b` input 32: multiplier / divisor; sampled with `start`.
- `hi_we` input 1: direct write of HI (MTHI).
- `lo_we` input 1: direct write of LO (MTLO).
- `wdata` input 32: data for `hi_we` / `lo_we`.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when HI/LO are updated by an operation.
- `div_zero` output 1: sticky flag; last completed divide had `b`=0.
- `hi` output 32: HI register (product high word / remainder).
- `lo` output 32: LO register (product low word / quotient).

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE:**
  - `start`=1 latches `op`, the operand sign bits and the absolute values of `a`/`b`.
  - Absolute values are taken for signed ops only; unsigned ops use raw values.
  - Clears the 5-bit iteration counter and enters RUN.
- **RUN:** one iteration per cycle; after the 32nd iteration (counter = 31), enters FIX.
  - Multiply: shift-add on a 64-bit accumulator {P, multiplier}.
  - Divide: restoring shift-subtract on {remainder, quotient}.
- **FIX:**
  - Applies sign correction and writes `hi`/`lo`.
  - Pulses `done`, updates `div_zero`, returns to IDLE.
- **Sign rules:**
  - MULT: 64-bit product negated if sign(a)^sign(b).
  - DIV: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - |−2^31| = 0x80000000 is handled as unsigned 32 bits.
  - −2^31 / −1 gives lo=0x80000000 and hi=0 (wraps, no trap).
- **Divide by zero:**
  - Full latency still runs.
  - Result: hi = `a` as sampled, lo = 0xFFFFFFFF, `div_zero`=1.
  - Any divide with `b`≠0 clears `div_zero`; multiplies leave it unchanged.
- **Direct writes:**
  - `hi_we`/`lo_we` write `wdata` only in IDLE with `start`=0.
  - They are ignored when `busy`=1 or `start`=1; `start` wins on collision.
  - Both enables together write both registers.
- **Ignored starts:** `start` while `busy`=1 is dropped, not queued.
- **Operand stability:** operands may change freely after the `start` cycle.
- **Result hold:** `hi`/`lo` hold their values until the next FIX or direct write.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, counter 0.
- **Reset mid-operation:** aborts with no result; HI/LO return to 0.
- **Launch:** `start` sampled at edge E0; `busy`=1 from E0 until E33.
- **Iterations:** RUN occupies edges E1..E32.
- **Completion:** FIX is evaluated at edge E33, which:
  - updates `hi`, `lo` and `div_zero`;
  - sets `done`=1 for exactly one cycle;
  - drops `busy` to 0.
- **Latency:** 33 cycles from the `start` sample to the result visible on `hi`/`lo`.
- **Back-to-back:** a new `start` is accepted at E33+1 at the earliest, when `done` is high and `busy` is low.
- **Direct-write latency:** value visible on the port the cycle after the edge.
- **Outputs:** all registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `reset` for 2 cycles → hi=lo=0, busy=done=div_zero=0. Then assert `reset` mid-RUN (cycle 10 of a MULT) → busy=0, hi=lo=0, no `done`.
- **MULTU:** a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, `done` high 1 cycle. Follow with MULT a=−3, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **Divide:**
  - DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
  - DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- **Divide by zero:** DIVU a=0x1234, b=0 → hi=0x1234, lo=0xFFFFFFFF, div_zero=1. Next DIVU 10/3 → div_zero=0, lo=3, hi=1.
- **Handshake:** pulse `start` again at cycle 5 of a busy op with different operands → ignored; the result matches the first op. `start` on the `done` cycle → accepted, second `done` 33 cycles later.
- **Direct writes:**
  - `hi_we` with wdata=0xA5A5A5A5 in IDLE → hi updated next cycle.
  - `lo_we` during RUN → no effect.
  - `lo_we` and `start` together → lo not written, op launches.
